ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 14 +
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and helpers for the two-requester RAM arbiter
package ram_arb_pkg;

   localparam int N_REQ = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // A word address is in range when no bit at or above awidth is set.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned awidth);
      return (addr >> awidth) == 32'd0;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; the pointer names the preferred requester
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic             pointer,
   output logic             winner,
   output logic             valid
);

   assign valid  = |req;
   assign winner = req[pointer] ? pointer : ~pointer;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port RAM between fetch (m0) and load/store (m1)
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [31:0]       m0_addr,
   input  logic [DWIDTH-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic              m0_err,
   output logic [DWIDTH-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [31:0]       m1_addr,
   input  logic [DWIDTH-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic              m1_err,
   output logic [DWIDTH-1:0] m1_rdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [31:0]       mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   state_t            r_state;
   logic              r_ptr;
   logic              r_winner;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [DWIDTH-1:0] r_wdata;
   logic              r_m0_gnt, r_m1_gnt, r_m0_rvalid, r_m1_rvalid, r_m0_err, r_m1_err;
   logic [DWIDTH-1:0] r_m0_rdata, r_m1_rdata;
   logic              r_mem_en, r_mem_wr;
   logic [31:0]       r_mem_addr;
   logic [DWIDTH-1:0] r_mem_wdata;

   logic [N_REQ-1:0]  w_req, w_mask, w_req_eff;
   logic              w_winner, w_valid, w_sel_we, w_sel_in_range, w_cur_in_range;
   logic [31:0]       w_sel_addr;
   logic [DWIDTH-1:0] w_sel_wdata, w_resp_data;

   // The requester being served this cycle may already be changing its inputs.
   assign w_req     = {m1_req, m0_req};
   assign w_mask    = (r_state == ACCESS) ? {r_winner, ~r_winner} : 2'b00;
   assign w_req_eff = w_req & ~w_mask;

   rr_pick2 u_pick (
      .req     (w_req_eff),
      .pointer (r_ptr),
      .winner  (w_winner),
      .valid   (w_valid)
   );

   assign w_sel_we       = w_winner ? m1_we    : m0_we;
   assign w_sel_addr     = w_winner ? m1_addr  : m0_addr;
   assign w_sel_wdata    = w_winner ? m1_wdata : m0_wdata;
   assign w_sel_in_range = addr_in_range(w_sel_addr, AWIDTH);
   assign w_cur_in_range = addr_in_range(r_addr, AWIDTH);
   assign w_resp_data    = (w_cur_in_range && !r_we) ? mem_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= 1'b0;
         r_winner    <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_m0_gnt    <= 1'b0;
         r_m1_gnt    <= 1'b0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m0_err    <= 1'b0;
         r_m1_err    <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_m0_gnt    <= 1'b0;
         r_m1_gnt    <= 1'b0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m0_err    <= 1'b0;
         r_m1_err    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         if (r_state == ACCESS) begin
            if (r_winner) begin
               r_m1_rvalid <= 1'b1;
               r_m1_err    <= ~w_cur_in_range;
               r_m1_rdata  <= w_resp_data;
            end else begin
               r_m0_rvalid <= 1'b1;
               r_m0_err    <= ~w_cur_in_range;
               r_m0_rdata  <= w_resp_data;
            end
         end
         if (w_valid) begin
            r_state  <= ACCESS;
            r_winner <= w_winner;
            r_ptr    <= ~w_winner;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_m0_gnt <= ~w_winner;
            r_m1_gnt <= w_winner;
            if (w_sel_in_range) begin
               r_mem_en    <= 1'b1;
               r_mem_wr    <= w_sel_we;
               r_mem_addr  <= w_sel_addr;
               r_mem_wdata <= w_sel_wdata;
            end
         end else begin
            r_state <= IDLE;
         end
      end
   end

   assign m0_gnt    = r_m0_gnt;
   assign m1_gnt    = r_m1_gnt;
   assign m0_rvalid = r_m0_rvalid;
   assign m1_rvalid = r_m1_rvalid;
   assign m0_err    = r_m0_err;
   assign m1_err    = r_m1_err;
   assign m0_rdata  = r_m0_rdata;
   assign m1_rdata  = r_m1_rdata;
   assign mem_en    = r_mem_en;
   assign mem_wr    = r_mem_wr;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter against a transaction model
module tb_ram_arbiter;

   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ram [256];

   always #5 clk = ~clk;

   ram_arbiter #(.AWIDTH(AW), .DWIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Environment RAM: combinational read, write at the end of the enabled cycle
   assign mem_rdata = mem_en ? ram[mem_addr[7:0]] : 32'h5A5A5A5A;
   always @(posedge clk) if (mem_en && mem_wr) ram[mem_addr[7:0]] <= mem_wdata;

   // Transaction model: who is being served, preferred requester, expected memory image
   int          cur = -1;
   int          pref = 0;
   logic        c_we = 0;
   logic [31:0] c_addr = 0, c_wdata = 0;
   logic [31:0] mmem [256];
   logic        e_gnt0 = 0, e_gnt1 = 0, e_rv0 = 0, e_rv1 = 0, e_err0 = 0, e_err1 = 0;
   logic [31:0] e_rd0 = 0, e_rd1 = 0;
   logic        e_en = 0, e_wr = 0;
   logic [31:0] e_addr = 0, e_wd = 0;

   function automatic logic inr(input logic [31:0] a);
      return a < (32'd1 << AW);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cur = -1; pref = 0; c_we = 0; c_addr = 0; c_wdata = 0;
         e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0;
         e_rd0 = 0; e_rd1 = 0; e_en = 0; e_wr = 0; e_addr = 0; e_wd = 0;
      end else begin
         logic [31:0] resp;
         logic e0, e1;
         int nw;
         e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0;
         if (cur >= 0) begin
            resp = (inr(c_addr) && !c_we) ? mmem[c_addr[7:0]] : 32'h0;
            if (inr(c_addr) && c_we) mmem[c_addr[7:0]] = c_wdata;
            if (cur == 0) begin e_rv0 = 1; e_err0 = !inr(c_addr); e_rd0 = resp; end
            else          begin e_rv1 = 1; e_err1 = !inr(c_addr); e_rd1 = resp; end
         end
         e0 = m0_req && (cur != 0);
         e1 = m1_req && (cur != 1);
         nw = (e0 && e1) ? pref : e0 ? 0 : e1 ? 1 : -1;
         e_gnt0 = (nw == 0); e_gnt1 = (nw == 1);
         e_en = 0; e_wr = 0; e_addr = 0; e_wd = 0;
         if (nw >= 0) begin
            c_we    = (nw == 1) ? m1_we    : m0_we;
            c_addr  = (nw == 1) ? m1_addr  : m0_addr;
            c_wdata = (nw == 1) ? m1_wdata : m0_wdata;
            pref    = 1 - nw;
            if (inr(c_addr)) begin e_en = 1; e_wr = c_we; e_addr = c_addr; e_wd = c_wdata; end
         end
         cur = nw;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m0_gnt",    32'(m0_gnt),    32'(e_gnt0));
      chk("m1_gnt",    32'(m1_gnt),    32'(e_gnt1));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
      chk("m0_err",    32'(m0_err),    32'(e_err0));
      chk("m1_err",    32'(m1_err),    32'(e_err1));
      chk("m0_rdata",  m0_rdata,       e_rd0);
      chk("m1_rdata",  m1_rdata,       e_rd1);
      chk("mem_en",    32'(mem_en),    32'(e_en));
      chk("mem_wr",    32'(mem_wr),    32'(e_wr));
      chk("mem_addr",  mem_addr,       e_addr);
      chk("mem_wdata", mem_wdata,      e_wd);
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic drive(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      if (i == 0) begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
      else        begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      rst = 1;
      tick(); tick();
      rst = 0;
   endtask

   logic        pend [2];
   logic [7:0]  gmask, rmask;
   int          m1_act;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]  = 32'h0100_0000 * i + 32'h0003_0507 * i + 32'h11;
         mmem[i] = ram[i];
      end
      ram[5] = 32'hDEADBEEF; mmem[5] = 32'hDEADBEEF;

      // Reset state, then single read of RAM[5]
      tick();
      chk("reset_ctrl", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en}), 32'h0);
      tick();
      rst = 0;
      drive(0, 1, 0, 32'h05, 0);
      tick();
      chk("rd5_gnt", 32'(m0_gnt), 32'h1);
      chk("rd5_mem_addr", mem_addr, 32'h05);
      drive(0, 0, 0, 0, 0);
      tick();
      chk("rd5_rvalid", 32'(m0_rvalid), 32'h1);
      chk("rd5_rdata", m0_rdata, 32'hDEADBEEF);
      chk("rd5_err", 32'(m0_err), 32'h0);
      tick();

      // Simultaneous requests from reset: m0, m1, m0
      do_reset();
      drive(0, 1, 0, 32'h01, 0);
      drive(1, 1, 0, 32'h02, 0);
      tick();
      chk("both_first", 32'({m0_gnt, m1_gnt}), 32'h2);
      drive(0, 1, 0, 32'h03, 0);
      tick();
      chk("both_second", 32'({m0_gnt, m1_gnt}), 32'h1);
      drive(1, 0, 0, 0, 0);
      tick();
      chk("both_third", 32'({m0_gnt, m1_gnt}), 32'h2);
      drive(0, 0, 0, 0, 0);
      tick(); tick();

      // m1 write then m0 read-back
      drive(1, 1, 1, 32'h10, 32'h12345678);
      tick();
      chk("wr_gnt", 32'(m1_gnt), 32'h1);
      drive(1, 0, 0, 0, 0);
      tick();
      chk("wr_resp", {m1_rdata[30:0], m1_rvalid}, 32'h1);
      drive(0, 1, 0, 32'h10, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      tick();
      chk("rb_rdata", m0_rdata, 32'h12345678);
      tick();

      // Out-of-range read by m1
      drive(1, 1, 0, 32'h100, 0);
      tick();
      chk("oor_gnt_en", 32'({m1_gnt, mem_en}), 32'h2);
      drive(1, 0, 0, 0, 0);
      tick();
      chk("oor_resp", 32'({m1_rvalid, m1_err}), 32'h3);
      chk("oor_rdata", m1_rdata, 32'h0);
      tick();

      // Reset during an m0 access
      drive(0, 1, 0, 32'h07, 0);
      tick();
      chk("ra_gnt", 32'({m0_gnt, mem_en}), 32'h3);
      drive(0, 0, 0, 0, 0);
      rst = 1;
      #1;
      chk("ra_async_ctrl", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_en, mem_wr}), 32'h0);
      chk("ra_async_addr", mem_addr, 32'h0);
      chk("ra_async_rdata", m0_rdata, 32'h0);
      tick();
      rst = 0;
      tick();
      chk("ra_no_rvalid", 32'(m0_rvalid), 32'h0);
      drive(0, 1, 0, 32'h08, 0);
      drive(1, 1, 0, 32'h09, 0);
      tick();
      chk("ra_ptr_m0", 32'({m0_gnt, m1_gnt}), 32'h2);
      drive(0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0);
      tick(); tick();

      // m0 alone for four accesses: grant every other cycle
      gmask = 0; rmask = 0; m1_act = 0;
      drive(0, 1, 0, 32'h20, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         gmask[k] = m0_gnt;
         rmask[k] = m0_rvalid;
         if (m1_gnt || m1_rvalid || m1_err) m1_act++;
         if (k == 6) drive(0, 0, 0, 0, 0);
         else if (m0_gnt) drive(0, 1, 0, 32'h21 + k, 0);
      end
      chk("solo_gnt_pattern", 32'(gmask), 32'h55);
      chk("solo_rvalid_pattern", 32'(rmask), 32'hAA);
      chk("solo_no_m1", 32'(m1_act), 32'h0);
      tick();

      // Randomized traffic
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && ((i == 0) ? e_gnt0 : e_gnt1)) pend[i] = 0;
            if (!pend[i] && $urandom_range(0, 99) < 45) begin
               pend[i] = 1;
               drive(i, 1, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 15)) : ($urandom | 32'h100),
                     $urandom);
            end else if (!pend[i]) begin
               drive(i, 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
         end
         tick();
      end
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      tick(); tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
